// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one multi-cycle, pipelined main memory between the I-cache and the
//   D-cache. Block fills are issued as WORDS back-to-back reads, and the
//   returning words are counted back in. D-cache stores go out as single-word
//   writes. The D side wins simultaneous requests, and a running operation is
//   never preempted. After reset the arbiter waits long enough for reads still
//   in flight from an aborted fill to come back from memory before it grants
//   again.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_req, i_addr     I-cache fill request (level) and miss address
//   d_req, d_wr       D-cache request (level); d_wr=1 store, 0 block fill
//   d_addr, d_wdata   D-cache address and store data
//   mem_rdata         memory read data
//   mem_valid         mem_rdata valid this cycle
//   mem_en, mem_wr    memory access strobe and write qualifier
//   mem_addr          memory access address
//   mem_wdata         store data to memory (d_wdata pass-through)
//   i_fill_valid      fill word for the I side on fill_data this cycle
//   d_fill_valid      fill word for the D side on fill_data this cycle
//   fill_idx          word index within the block of the current fill word
//   fill_data         mem_rdata pass-through
//   i_done, d_done    one-cycle completion pulses
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic                      d_req,
  input  logic                      d_wr,
  input  logic [ADDR_W-1:0]         d_addr,
  input  logic [DATA_W-1:0]         d_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_valid,
  output logic                      mem_en,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      i_fill_valid,
  output logic                      d_fill_valid,
  output logic [$clog2(WORDS)-1:0]  fill_idx,
  output logic [DATA_W-1:0]         fill_data,
  output logic                      i_done,
  output logic                      d_done
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int LAT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  // Byte offset within one block of WORDS 2-byte words.
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(WORDS * 2 - 1);

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_DWRITE,
    S_FILL,
    S_DONE
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [LAT_W-1:0]   drain_cnt;
  logic [CNT_W-1:0]   issue_cnt;
  logic [IDX_W-1:0]   recv_cnt;
  logic               owner_d;
  logic [ADDR_W-1:0]  base;

  assign fill_data = mem_rdata;
  assign mem_wdata = d_wdata;

  // ---- state register and counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_DRAIN;
      drain_cnt <= LAT_W'(MEM_LAT);
      issue_cnt <= '0;
      recv_cnt  <= '0;
      owner_d   <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        S_DRAIN: begin
          if (drain_cnt != '0) drain_cnt <= drain_cnt - LAT_W'(1);
        end
        S_IDLE: begin
          issue_cnt <= '0;
          recv_cnt  <= '0;
          if (d_req)      owner_d <= 1'b1;
          else if (i_req) owner_d <= 1'b0;
        end
        S_FILL: begin
          if (issue_cnt < CNT_W'(WORDS)) issue_cnt <= issue_cnt + CNT_W'(1);
          // recv_cnt wraps to 0 on the last word; the FSM leaves FILL then.
          if (mem_valid) recv_cnt <= recv_cnt + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Block base is datapath: latched on every IDLE cycle, only used in FILL.
  always_ff @(posedge clk) begin
    if (state == S_IDLE) base <= (d_req ? d_addr : i_addr) & ~BLK_MASK;
  end

  // ---- next-state logic ----
  always_comb begin
    next_state = state;
    case (state)
      S_DRAIN:  if (drain_cnt == '0) next_state = S_IDLE;
      S_IDLE: begin
        if (d_req)      next_state = d_wr ? S_DWRITE : S_FILL;
        else if (i_req) next_state = S_FILL;
      end
      S_DWRITE: next_state = S_DONE;
      S_FILL:   if (mem_valid && recv_cnt == IDX_W'(WORDS - 1)) next_state = S_DONE;
      // Requester drops req during DONE; going straight to IDLE avoids a regrant.
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_DRAIN;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    fill_idx     = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    case (state)
      S_DWRITE: begin
        mem_en   = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = d_addr;
      end
      S_FILL: begin
        if (issue_cnt < CNT_W'(WORDS)) begin
          mem_en   = 1'b1;
          mem_addr = base + ADDR_W'({issue_cnt, 1'b0});
        end
        i_fill_valid = mem_valid & ~owner_d;
        d_fill_valid = mem_valid & owner_d;
        fill_idx     = recv_cnt;
      end
      S_DONE: begin
        i_done = ~owner_d;
        d_done = owner_d;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int WORDS   = 8;
  localparam int MEM_LAT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              d_req = 1'b0;
  logic              d_wr = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_valid = 1'b0;
  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              i_fill_valid, d_fill_valid;
  logic [2:0]        fill_idx;
  logic [DATA_W-1:0] fill_data;
  logic              i_done, d_done;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .fill_idx(fill_idx), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                is_d;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                exp_lat;
  } vec_t;

  typedef struct {
    bit                side;   // 1 = D
    int                idx;
    logic [DATA_W-1:0] data;
  } fill_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic [ADDR_W-1:0] exp_addr_q[$];
  fill_t             exp_fill_q[$];
  wr_t               exp_wr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_idone = 0, n_ddone = 0;
  int i_done_cyc = 0, d_done_cyc = 0;
  int fills_seen = 0;
  int first_en_cyc = -1;
  bit s_any = 1'b0;
  bit s_fill = 1'b0;

  // memory model: read issued in cycle c returns in cycle c+MEM_LAT
  bit                pipe_v[MEM_LAT];
  logic [ADDR_W-1:0] pipe_a[MEM_LAT];
  bit                iss_pend = 1'b0;
  logic [ADDR_W-1:0] iss_addr = '0;
  bit                stray = 1'b0;

  function automatic logic [DATA_W-1:0] mdata(input logic [ADDR_W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected / not reached (cycle %0d)", name, cyc);
  endtask

  task automatic mem_drive();
    mem_valid = pipe_v[MEM_LAT-1] | stray;
    mem_rdata = pipe_v[MEM_LAT-1] ? mdata(pipe_a[MEM_LAT-1]) : 16'hDEAD;
  endtask

  task automatic monitor();
    fill_t f;
    wr_t   w;
    iss_pend = 1'b0;
    s_any  = mem_en | mem_wr | i_fill_valid | d_fill_valid | i_done | d_done | (mem_addr != '0);
    s_fill = i_fill_valid | d_fill_valid;
    if (mem_en === 1'b1 && first_en_cyc < 0) first_en_cyc = cyc;
    if (mem_en === 1'b1 && mem_wr === 1'b1) begin
      if (exp_wr_q.size() == 0) fail("unexpected_write");
      else begin
        w = exp_wr_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(w.addr));
        check("wr_data", 32'(mem_wdata), 32'(w.data));
      end
    end else if (mem_en === 1'b1) begin
      iss_pend = 1'b1;
      iss_addr = mem_addr;
      if (exp_addr_q.size() == 0) fail("unexpected_read");
      else check("rd_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
    end
    if (i_fill_valid === 1'b1 || d_fill_valid === 1'b1) begin
      fills_seen++;
      if (exp_fill_q.size() == 0) fail("unexpected_fill");
      else begin
        f = exp_fill_q.pop_front();
        check("fill_side_d", 32'(d_fill_valid), 32'(f.side));
        check("fill_side_i", 32'(i_fill_valid), 32'(!f.side));
        check("fill_idx", 32'(fill_idx), 32'(f.idx));
        check("fill_data", 32'(fill_data), 32'(f.data));
      end
    end
    if (i_done === 1'b1) begin n_idone++; i_done_cyc = cyc; i_req = 1'b0; end
    if (d_done === 1'b1) begin n_ddone++; d_done_cyc = cyc; d_req = 1'b0; d_wr = 1'b0; end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = MEM_LAT - 1; k > 0; k--) begin
      pipe_v[k] = pipe_v[k-1];
      pipe_a[k] = pipe_a[k-1];
    end
    pipe_v[0] = iss_pend;
    pipe_a[0] = iss_addr;
    mem_drive();
  endtask

  task automatic flush();
    exp_addr_q.delete();
    exp_fill_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic expect_fill(input bit side, input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] base;
    fill_t f;
    base = addr & ~16'h000F;
    for (int k = 0; k < WORDS; k++) begin
      exp_addr_q.push_back(base + 16'(2 * k));
      f.side = side;
      f.idx  = k;
      f.data = mdata(base + 16'(2 * k));
      exp_fill_q.push_back(f);
    end
  endtask

  task automatic wait_for(input int ni, input int nd, input int bound);
    int k;
    k = 0;
    while ((n_idone < ni || n_ddone < nd) && k < bound) begin
      tick();
      k++;
    end
    if (n_idone < ni || n_ddone < nd) fail("done_timeout");
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    tick();
    flush();
    rst = 1'b0;
    for (int k = 0; k < MEM_LAT + 1; k++) begin
      tick();
      check("drain_quiet", 32'(s_any), 32'd0);
    end
  endtask

  task automatic run_req(input vec_t v);
    int t0, ni0, nd0;
    wr_t w;
    ni0 = n_idone; nd0 = n_ddone; t0 = cyc;
    if (v.is_d && v.wr) begin
      w.addr = v.addr; w.data = v.wdata;
      exp_wr_q.push_back(w);
    end else expect_fill(v.is_d, v.addr);
    if (v.is_d) begin d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1; end
    else begin i_addr = v.addr; i_req = 1'b1; end
    wait_for(ni0 + (v.is_d ? 0 : 1), nd0 + (v.is_d ? 1 : 0), 40);
    if (v.is_d) check("d_done_lat", 32'(d_done_cyc - t0), 32'(v.exp_lat));
    else        check("i_done_lat", 32'(i_done_cyc - t0), 32'(v.exp_lat));
    check("other_done", 32'(v.is_d ? n_idone - ni0 : n_ddone - nd0), 32'd0);
    check("queues_empty", 32'(exp_addr_q.size() + exp_fill_q.size() + exp_wr_q.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v;
    wr_t  w;
    int   t0, r1, ni0, f0;

    vecs[0] = '{is_d: 1'b0, wr: 1'b0, addr: 16'h1236, wdata: 16'h0000, exp_lat: 13};
    vecs[1] = '{is_d: 1'b1, wr: 1'b0, addr: 16'h00F1, wdata: 16'h0000, exp_lat: 13};
    vecs[2] = '{is_d: 1'b1, wr: 1'b1, addr: 16'h0040, wdata: 16'hBEEF, exp_lat: 2};
    vecs[3] = '{is_d: 1'b0, wr: 1'b0, addr: 16'hFFFE, wdata: 16'h0000, exp_lat: 13};
    vecs[4] = '{is_d: 1'b1, wr: 1'b1, addr: 16'h1235, wdata: 16'h0001, exp_lat: 2};
    vecs[5] = '{is_d: 1'b1, wr: 1'b0, addr: 16'h8008, wdata: 16'h0000, exp_lat: 13};

    for (int k = 0; k < MEM_LAT; k++) begin pipe_v[k] = 1'b0; pipe_a[k] = '0; end

    // reset, then first grant timing after reset release
    rst = 1'b1;
    tick();
    tick();
    flush();
    rst = 1'b0;
    r1 = cyc;
    first_en_cyc = -1;
    i_addr = 16'h0100;
    i_req = 1'b1;
    expect_fill(1'b0, 16'h0100);
    wait_for(n_idone + 1, n_ddone, 40);
    check("first_grant_en", 32'(first_en_cyc - r1), 32'(MEM_LAT + 2));
    check("first_grant_done", 32'(i_done_cyc - r1), 32'(MEM_LAT + 1 + 13));

    do_reset();

    // table of single transactions
    foreach (vecs[k]) run_req(vecs[k]);

    // simultaneous I and D fill requests: D first
    t0 = cyc;
    expect_fill(1'b1, 16'h5550);
    expect_fill(1'b0, 16'h4444);
    i_addr = 16'h4444; i_req = 1'b1;
    d_addr = 16'h5550; d_wr = 1'b0; d_req = 1'b1;
    wait_for(n_idone + 1, n_ddone + 1, 60);
    check("both_d_done", 32'(d_done_cyc - t0), 32'd13);
    check("both_i_done", 32'(i_done_cyc - t0), 32'd27);

    // store raised mid I fill: waits for the fill
    t0 = cyc;
    expect_fill(1'b0, 16'h6000);
    i_addr = 16'h6000; i_req = 1'b1;
    tick(); tick(); tick();
    w.addr = 16'h0080; w.data = 16'h1234;
    exp_wr_q.push_back(w);
    d_addr = 16'h0080; d_wdata = 16'h1234; d_wr = 1'b1; d_req = 1'b1;
    wait_for(n_idone + 1, n_ddone + 1, 60);
    check("mid_i_done", 32'(i_done_cyc - t0), 32'd13);
    check("mid_d_done", 32'(d_done_cyc - t0), 32'd16);
    check("mid_queues", 32'(exp_addr_q.size() + exp_fill_q.size() + exp_wr_q.size()), 32'd0);

    // reset after 3 returned words aborts the fill
    ni0 = n_idone;
    f0 = fills_seen;
    expect_fill(1'b0, 16'h2000);
    i_addr = 16'h2000; i_req = 1'b1;
    for (int k = 0; k < 30 && fills_seen < f0 + 3; k++) tick();
    check("abort_words_before", 32'(fills_seen - f0), 32'd3);
    rst = 1'b1; i_req = 1'b0;
    tick();
    flush();
    rst = 1'b0;
    stray = 1'b1;
    mem_drive();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_no_fill", 32'(s_fill), 32'd0);
    end
    stray = 1'b0;
    mem_drive();
    tick();
    check("abort_no_done", 32'(n_idone - ni0), 32'd0);
    v = '{is_d: 1'b0, wr: 1'b0, addr: 16'h3008, wdata: 16'h0000, exp_lat: 13};
    run_req(v);

    // idle with stray mem_valid toggling
    for (int k = 0; k < 6; k++) begin
      stray = k[0];
      mem_drive();
      tick();
      check("idle_quiet", 32'(s_any), 32'd0);
    end
    stray = 1'b0;
    mem_drive();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
